// File: rtl/if_id_queue_pkg.sv
// Shared definitions for the fetch/decode boundary: datapath width, the
// bubble instruction shown to decode when nothing is buffered, and the
// fetch-packet layout that fetch, the queue and decode all agree on.
package if_id_queue_pkg;

   localparam int XLEN = 32;

   // addi x0,x0,0 -- a harmless bubble for decode when the queue is empty.
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_pkt_t;

endpackage : if_id_queue_pkg

// File: rtl/if_id_queue_mem.sv
// DEPTH-entry fetch-packet storage: one synchronous write port and one
// asynchronous read port. Only the queue's pointers decide which entries
// hold live data, so the array itself never needs clearing.
module if_id_queue_mem
   import if_id_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  fetch_pkt_t    wdata,
   input  logic [AW-1:0] raddr,
   output fetch_pkt_t    rdata
);

   fetch_pkt_t mem_q [DEPTH];
   fetch_pkt_t mem_d [DEPTH];

   // Next array contents: hold every entry, overwrite the addressed one on write.
   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   // Storage register.
   // NOTE: the array has no reset on purpose -- stale entries are unreachable
   // once the pointers and count are cleared, and a reset here only costs area.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[raddr];

endmodule : if_id_queue_mem

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: buffers {pc, instr} pairs from fetch and hands
// them to decode in order over a valid/ready handshake. A taken-jump
// redirect (flush) discards everything buffered.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// Optional build macro IF_ID_BYPASS_EN: when the queue is empty a valid
// input pair is forwarded combinationally to decode (zero-latency path).
module if_id_queue
   import if_id_queue_pkg::XLEN;
   import if_id_queue_pkg::fetch_pkt_t;
#(
   parameter int              DEPTH     = 4,
   parameter logic [XLEN-1:0] NOP_INSTR = if_id_queue_pkg::NOP_INSTR
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [XLEN-1:0]          in_pc,
   input  logic [XLEN-1:0]          in_instr,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [XLEN-1:0]          out_pc,
   output logic [XLEN-1:0]          out_instr,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;

   fetch_pkt_t in_pkt;
   fetch_pkt_t head_pkt;
   logic       empty;
   logic       bypass;
   logic       push;
   logic       pop;
   logic       mem_we;

   if_id_queue_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr_q),
      .wdata (in_pkt),
      .raddr (rd_ptr_q),
      .rdata (head_pkt)
   );

   // Handshake and decode-facing outputs; apart from the optional bypass these
   // depend on registered state only, so no input reaches an output.
   // NOTE: every signal gets a default first so no path through the block can
   // leave a value unassigned and infer a latch.
   always_comb begin
      in_pkt    = '{pc: in_pc, instr: in_instr};
      empty     = (count_q == '0);
      bypass    = 1'b0;
`ifdef IF_ID_BYPASS_EN
      bypass    = empty && in_valid && !flush;
`endif
      // No pop-through: a full queue refuses input even while decode pops.
      in_ready  = (count_q < CW'(DEPTH));
      out_valid = !empty || bypass;
      out_pc    = '0;
      out_instr = NOP_INSTR;
      if (bypass) begin
         out_pc    = in_pc;
         out_instr = in_instr;
      end else if (!empty) begin
         out_pc    = head_pkt.pc;
         out_instr = head_pkt.instr;
      end
      // Pops only ever come from stored entries; a bypassed pair that decode
      // takes immediately is never written at all.
      pop  = !empty && out_ready;
      push = in_valid && in_ready && !(bypass && out_ready);
   end

   // Next pointer and occupancy state; flush overrides any same-cycle push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_we   = 1'b0;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // State registers with synchronous active-low reset.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // its _d value from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count = count_q;

endmodule : if_id_queue
